add_float_unit: RTL and testbench



---
 rtl/float_pkg.sv | 49 ++++
 rtl/lzc.sv | 18 +
 rtl/add_float_unit.sv | 207 ++++++++++++++++++++
 tb/tb_add_float_unit.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/float_pkg.sv
// Shared definitions for the floating-point adder: format geometry per width,
// the sequencing state enum and the special-value bit patterns.
package float_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ALIGN,
        ST_ADD,
        ST_NORM,
        ST_ROUND
    } state_t;

    // Exponent field width; 0 marks an unsupported format width.
    function automatic int exp_bits(input int fw);
        case (fw)
            16:      return 5;
            32:      return 8;
            64:      return 11;
            default: return 0;
        endcase
    endfunction

    // Fraction field width (hidden bit excluded).
    function automatic int frac_bits(input int fw);
        case (fw)
            16:      return 10;
            32:      return 23;
            64:      return 52;
            default: return 0;
        endcase
    endfunction

    // Exponent bias for the format.
    function automatic int exp_bias(input int fw);
        if (exp_bits(fw) == 0) return 0;
        return (1 << (exp_bits(fw) - 1)) - 1;
    endfunction

    // Canonical quiet NaN: sign 0, exponent all ones, fraction MSB set.
    function automatic logic [63:0] qnan_bits(input int fw);
        return ((64'd1 << (exp_bits(fw) + 1)) - 64'd1) << (frac_bits(fw) - 1);
    endfunction

    // Positive infinity: exponent all ones, fraction zero.
    function automatic logic [63:0] inf_bits(input int fw);
        return ((64'd1 << exp_bits(fw)) - 64'd1) << frac_bits(fw);
    endfunction

endpackage

// File: rtl/lzc.sv
// Parameterized leading-zero counter; an all-zero input yields WIDTH.
module lzc #(
    parameter int WIDTH = 27,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] value,
    output logic [CW-1:0]    count
);

    // Scan upward so the highest set bit is the last one to win.
    always_comb begin
        count = CW'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (value[i]) count = CW'(WIDTH - 1 - i);
        end
    end

endmodule

// File: rtl/add_float_unit.sv
// Multi-cycle IEEE-754 adder/subtractor with flush-to-zero and a start/done
// handshake. One operation in flight; result and flags held until the next.
module add_float_unit
    import float_pkg::*;
#(
    parameter int FLOAT_WIDTH = 32
) (
    input  logic                   rst_n,
    input  logic                   clk,
    input  logic                   start,
    input  logic                   sub,
    input  logic [FLOAT_WIDTH-1:0] a,
    input  logic [FLOAT_WIDTH-1:0] b,
    output logic [FLOAT_WIDTH-1:0] o,
    output logic                   nan,
    output logic                   overflow,
    output logic                   underflow,
    output logic                   zero,
    output logic                   done
);

    localparam int EW = exp_bits(FLOAT_WIDTH);
    localparam int FW = frac_bits(FLOAT_WIDTH);
    localparam int MW = FW + 4;          // hidden bit + fraction + guard/round/sticky
    localparam int XW = EW + 2;          // signed working exponent
    localparam int LW = $clog2(MW + 1);
    localparam logic [FLOAT_WIDTH-1:0] QNAN    = FLOAT_WIDTH'(qnan_bits(FLOAT_WIDTH));
    localparam logic [FLOAT_WIDTH-2:0] INF_MAG = (FLOAT_WIDTH - 1)'(inf_bits(FLOAT_WIDTH));
    localparam logic signed [XW-1:0]   EXP_MAX = XW'((1 << EW) - 1);

    if (EW == 0) begin : g_bad_width
        $error("add_float_unit: FLOAT_WIDTH must be 16, 32 or 64");
    end

    state_t            state;
    logic              sign_a, sign_b, nan_in, inf_a, inf_b;
    logic [EW-1:0]     exp_a, exp_b, big_exp;
    logic [MW-1:0]     man_a, man_b, big_man, small_man, norm_man;
    logic              big_sign, zero_sign, eff_sub;
    logic              special_nan, special_inf, inf_sign;
    logic [MW:0]       sum;
    logic signed [XW-1:0] norm_exp;

    // Raw field views of the operand inputs.
    logic [EW-1:0] a_exp_in, b_exp_in;
    logic [FW-1:0] a_frac_in, b_frac_in;
    assign a_exp_in  = a[FLOAT_WIDTH-2 -: EW];
    assign b_exp_in  = b[FLOAT_WIDTH-2 -: EW];
    assign a_frac_in = a[FW-1:0];
    assign b_frac_in = b[FW-1:0];

    // Alignment: pick the larger magnitude and shift the other right with sticky.
    logic          a_first, shift_sticky;
    logic [EW-1:0] small_exp, exp_diff;
    logic [MW-1:0] small_raw, shifted;
    always_comb begin
        a_first   = {exp_a, man_a} >= {exp_b, man_b};
        small_exp = a_first ? exp_b : exp_a;
        small_raw = a_first ? man_b : man_a;
        exp_diff  = (a_first ? exp_a : exp_b) - small_exp;
        if (32'(exp_diff) >= MW) begin
            shifted      = '0;
            shift_sticky = |small_raw;
        end else begin
            shifted      = small_raw >> exp_diff;
            shift_sticky = |(small_raw & ~({MW{1'b1}} << exp_diff));
        end
    end

    logic [LW-1:0] lead_zeros;
    lzc #(.WIDTH(MW), .CW(LW)) u_lzc (
        .value (sum[MW-1:0]),
        .count (lead_zeros)
    );

    // Round to nearest even, renormalize, then classify the final result.
    logic                 round_up;
    logic [FW+1:0]        rounded;
    logic signed [XW-1:0] final_exp;
    logic [FW-1:0]        final_frac;
    logic [FLOAT_WIDTH-1:0] res_o;
    logic                 res_nan, res_ovf, res_unf, res_zero;
    always_comb begin
        round_up = norm_man[2] & (norm_man[1] | norm_man[0] | norm_man[3]);
        rounded  = {1'b0, norm_man[MW-1:3]} + {{(FW + 1){1'b0}}, round_up};
        if (rounded[FW+1]) begin
            final_exp  = norm_exp + XW'(1);
            final_frac = rounded[FW:1];
        end else begin
            final_exp  = norm_exp;
            final_frac = rounded[FW-1:0];
        end
        res_nan  = 1'b0;
        res_ovf  = 1'b0;
        res_unf  = 1'b0;
        res_zero = 1'b0;
        if (special_nan) begin
            res_o   = QNAN;
            res_nan = 1'b1;
        end else if (special_inf) begin
            res_o = {inf_sign, INF_MAG};
        end else if (norm_man == '0) begin
            res_o    = {zero_sign, {(FLOAT_WIDTH - 1){1'b0}}};
            res_zero = 1'b1;
        end else if (final_exp >= EXP_MAX) begin
            res_o   = {big_sign, INF_MAG};
            res_ovf = 1'b1;
        end else if (final_exp[XW-1] || final_exp == '0) begin
            res_o    = {big_sign, {(FLOAT_WIDTH - 1){1'b0}}};
            res_unf  = 1'b1;
            res_zero = 1'b1;
        end else begin
            res_o = {big_sign, final_exp[EW-1:0], final_frac};
        end
    end

    // Sequencer: capture, align, add, normalize, round; outputs registered on ROUND.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            sign_a      <= 1'b0;
            sign_b      <= 1'b0;
            nan_in      <= 1'b0;
            inf_a       <= 1'b0;
            inf_b       <= 1'b0;
            exp_a       <= '0;
            exp_b       <= '0;
            man_a       <= '0;
            man_b       <= '0;
            big_sign    <= 1'b0;
            big_exp     <= '0;
            big_man     <= '0;
            small_man   <= '0;
            eff_sub     <= 1'b0;
            zero_sign   <= 1'b0;
            special_nan <= 1'b0;
            special_inf <= 1'b0;
            inf_sign    <= 1'b0;
            sum         <= '0;
            norm_man    <= '0;
            norm_exp    <= '0;
            o           <= '0;
            nan         <= 1'b0;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
            zero        <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        sign_a <= a[FLOAT_WIDTH-1];
                        sign_b <= b[FLOAT_WIDTH-1] ^ sub;
                        exp_a  <= a_exp_in;
                        exp_b  <= b_exp_in;
                        // Subnormals enter the datapath as zero.
                        man_a  <= (a_exp_in == '0) ? '0 : {1'b1, a_frac_in, 3'b000};
                        man_b  <= (b_exp_in == '0) ? '0 : {1'b1, b_frac_in, 3'b000};
                        nan_in <= (&a_exp_in && |a_frac_in) || (&b_exp_in && |b_frac_in);
                        inf_a  <= &a_exp_in && ~|a_frac_in;
                        inf_b  <= &b_exp_in && ~|b_frac_in;
                        state  <= ST_ALIGN;
                    end
                end
                ST_ALIGN: begin
                    big_sign    <= a_first ? sign_a : sign_b;
                    big_exp     <= a_first ? exp_a : exp_b;
                    big_man     <= a_first ? man_a : man_b;
                    small_man   <= shifted | {{(MW - 1){1'b0}}, shift_sticky};
                    eff_sub     <= sign_a ^ sign_b;
                    zero_sign   <= sign_a & sign_b;
                    special_nan <= nan_in || (inf_a && inf_b && (sign_a != sign_b));
                    special_inf <= inf_a || inf_b;
                    inf_sign    <= inf_a ? sign_a : sign_b;
                    state       <= ST_ADD;
                end
                ST_ADD: begin
                    sum   <= eff_sub ? ({1'b0, big_man} - {1'b0, small_man})
                                     : ({1'b0, big_man} + {1'b0, small_man});
                    state <= ST_NORM;
                end
                ST_NORM: begin
                    if (sum[MW]) begin
                        norm_man <= sum[MW:1] | {{(MW - 1){1'b0}}, sum[0]};
                        norm_exp <= XW'(big_exp) + XW'(1);
                    end else begin
                        norm_man <= sum[MW-1:0] << lead_zeros;
                        norm_exp <= XW'(big_exp) - XW'(lead_zeros);
                    end
                    state <= ST_ROUND;
                end
                ST_ROUND: begin
                    o         <= res_o;
                    nan       <= res_nan;
                    overflow  <= res_ovf;
                    underflow <= res_unf;
                    zero      <= res_zero;
                    done      <= 1'b1;
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_add_float_unit.sv
// Bench for add_float_unit at 32 bits: directed corner cases plus random
// operands checked against a real-arithmetic reference model.
module tb_add_float_unit;

    logic        rst_n, clk, start, sub;
    logic [31:0] a, b, o;
    logic        nan, overflow, underflow, zero, done;
    int          checks   = 0;
    int          failures = 0;

    add_float_unit #(.FLOAT_WIDTH(32)) dut (
        .rst_n     (rst_n),
        .clk       (clk),
        .start     (start),
        .sub       (sub),
        .a         (a),
        .b         (b),
        .o         (o),
        .nan       (nan),
        .overflow  (overflow),
        .underflow (underflow),
        .zero      (zero),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Exact real value of a single-precision pattern (subnormals read as zero).
    function automatic real val_of(input logic [31:0] x);
        real m;
        int  e;
        e = int'(x[30:23]);
        if (e == 0) return 0.0;
        m = (1.0 + real'(x[22:0]) / 8388608.0) * (2.0 ** (e - 127));
        return x[31] ? -m : m;
    endfunction

    // Reference: exact sum in double, then round-to-nearest-even into single
    // with flush-to-zero. Returns {nan, overflow, underflow, zero, result}.
    function automatic logic [35:0] model_add(input logic [31:0] x, input logic [31:0] y,
                                              input logic s);
        real    r, mag, m, fl;
        int     e;
        longint mi;
        logic   sg;
        r = val_of(x) + (s ? -val_of(y) : val_of(y));
        if (r == 0.0) return {4'b0001, x[31] & (y[31] ^ s), 31'b0};
        sg  = (r < 0.0);
        mag = sg ? -r : r;
        e   = 0;
        while (mag >= 2.0) begin mag = mag / 2.0; e++; end
        while (mag < 1.0)  begin mag = mag * 2.0; e--; end
        m  = mag * 8388608.0;
        fl = $floor(m);
        mi = longint'(fl);
        if ((m - fl > 0.5) || ((m - fl == 0.5) && mi[0])) mi++;
        if (mi == 64'd16777216) begin
            mi = 64'd8388608;
            e++;
        end
        e = e + 127;
        if (e >= 255) return {4'b0100, sg, 8'hFF, 23'h0};
        if (e <= 0)   return {4'b0011, sg, 31'h0};
        return {4'b0000, sg, e[7:0], mi[22:0]};
    endfunction

    // One operation with full latency and handshake checks.
    task automatic run_op(input string tag, input logic [31:0] x, input logic [31:0] y,
                          input logic s, input logic [31:0] exp_o, input logic [3:0] exp_f);
        @(posedge clk); #1;
        a = x; b = y; sub = s; start = 1'b1;
        @(posedge clk); #1;                      // capture edge N
        start = 1'b0; a = $urandom; b = $urandom; sub = 1'($urandom_range(0, 1));
        repeat (3) @(posedge clk);
        #1;
        check({tag, " early_done"}, {31'b0, done}, 32'd0);
        @(posedge clk); #1;                      // edge N+4
        check({tag, " done"}, {31'b0, done}, 32'd1);
        check({tag, " o"}, o, exp_o);
        check({tag, " flags"}, {28'b0, nan, overflow, underflow, zero}, {28'b0, exp_f});
        @(posedge clk); #1;
        check({tag, " done_pulse"}, {31'b0, done}, 32'd0);
        check({tag, " o_hold"}, o, exp_o);
        $display("op %s a=%h b=%h sub=%0d o=%h flags=%b", tag, x, y, s, o,
                 {nan, overflow, underflow, zero});
    endtask

    initial begin
        logic [35:0] expect_v;
        logic [31:0] x, y;
        logic        s;
        int          ea, eb, seen;

        rst_n = 1'b0; start = 1'b0; sub = 1'b0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset o", o, 32'h0);
        check("reset flags", {27'b0, nan, overflow, underflow, zero, done}, 32'h0);
        rst_n = 1'b1;

        run_op("add5p5",    32'h40A00000, 32'h40A00000, 1'b0, 32'h41200000, 4'b0000);
        run_op("sub_zero",  32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'b0001);
        run_op("overflow",  32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b0100);
        run_op("nan_in",    32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b1000);
        run_op("inf_m_inf", 32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 4'b1000);
        run_op("underflow", 32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 4'b0011);
        run_op("tie_even",  32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0000);
        run_op("one_inf",   32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 4'b0000);
        run_op("inf_p_inf", 32'hFF800000, 32'hFF800000, 1'b0, 32'hFF800000, 4'b0000);
        run_op("neg_zeros", 32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'b0001);
        run_op("nz_m_pz",   32'h80000000, 32'h00000000, 1'b1, 32'h80000000, 4'b0001);
        run_op("subnormal", 32'h00000001, 32'h3F800000, 1'b0, 32'h3F800000, 4'b0000);

        for (int k = 0; k < 40; k++) begin
            if (k < 5)       ea = 254;
            else if (k < 10) ea = 1;
            else             ea = int'($urandom_range(1, 254));
            eb = ea + int'($urandom_range(0, 40)) - 20;
            if (eb < 1)   eb = 1;
            if (eb > 254) eb = 254;
            x = {1'($urandom_range(0, 1)), ea[7:0], 23'($urandom)};
            y = {1'($urandom_range(0, 1)), eb[7:0], 23'($urandom)};
            s = 1'($urandom_range(0, 1));
            expect_v = model_add(x, y, s);
            run_op($sformatf("rand%0d", k), x, y, s, expect_v[31:0], expect_v[35:32]);
        end

        // start held high: a result every fifth edge, nothing in between.
        @(posedge clk); #1;
        a = 32'h40A00000; b = 32'h40A00000; sub = 1'b0; start = 1'b1;
        for (int i = 1; i <= 15; i++) begin
            @(posedge clk); #1;
            check($sformatf("held done@%0d", i), {31'b0, done}, (i % 5 == 0) ? 32'd1 : 32'd0);
            if (i % 5 == 0) check($sformatf("held o@%0d", i), o, 32'h41200000);
            if (i == 15) start = 1'b0;
        end
        @(posedge clk); #1;
        check("held after", {31'b0, done}, 32'd0);
        $display("op held_start dones at edges 5,10,15 o=%h", o);

        // Reset asserted mid-operation aborts with no done and cleared outputs.
        @(posedge clk); #1;
        a = 32'h3F800000; b = 32'h40000000; sub = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("midrst o", o, 32'h0);
        check("midrst flags", {27'b0, nan, overflow, underflow, zero, done}, 32'h0);
        #2 rst_n = 1'b1;
        seen = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (done) seen++;
        end
        check("midrst no_done", 32'(seen), 32'd0);
        check("midrst o_after", o, 32'h0);
        $display("op reset_mid_op o=%h dones=%0d", o, seen);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
